spi_txn_arbiter: RTL and testbench

Two-requester SPI transaction controller. Grants the shared SPI bus to one requester at a time using round-robin arbitration. Generates sclk from clk, sequences per-requester chip-select and shifts one DATA_W-bit word in SPI mode 0 (CPOL=0, CPHA=0), MSB first. It replaces free-running sclk generation with transaction-framed clocking.

---
 rtl/spi_txn_arbiter.sv | 142 ++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// Two-requester round-robin SPI mode-0 transaction controller with framed sclk.
// Optional build macro SPI_LOOPBACK_EN routes mosi back as receive data.
module spi_txn_arbiter #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 16,
  parameter int CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] tx_data0,
  input  logic [DATA_W-1:0] tx_data1,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [1:0]        cs_n
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HP_W  = $clog2(2 * DATA_W + CS_GAP + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [HP_W-1:0]  XFER_LAST = HP_W'(2 * DATA_W - 1);
  localparam logic [HP_W-1:0]  GAP_LAST  = HP_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [HP_W-1:0]   hp;
  logic [DATA_W-1:0] sh;
  logic              in_bit;
  logic              owner;
  logic              last_srv;
  logic              pick;
  logic              tick;
  logic              rx_in;

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_in       = mosi;
`else
  assign rx_in       = miso;
`endif

  assign tick = (cnt == CNT_LAST);
  assign busy = (state != S_IDLE);

  // On contention the requester not served last wins.
  always_comb begin
    // NOTE: default assigned first so this block can never infer a latch.
    pick = ~last_srv;
    if (req == 2'b01)      pick = 1'b0;
    else if (req == 2'b10) pick = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: all state uses <= so every register sees pre-edge values.
      state    <= S_IDLE;
      cnt      <= '0;
      hp       <= '0;
      sh       <= '0;
      in_bit   <= 1'b0;
      owner    <= 1'b0;
      last_srv <= 1'b1;
      grant    <= 2'b00;
      done     <= 2'b00;
      rx_data  <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 2'b11;
    end else begin
      done <= 2'b00;
      if (state == S_IDLE || tick) cnt <= '0;
      else                         cnt <= cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (|req) begin
            state    <= S_SETUP;
            owner    <= pick;
            last_srv <= pick;
            hp       <= '0;
            grant    <= pick ? 2'b10 : 2'b01;
            cs_n     <= pick ? 2'b01 : 2'b10;
            sh       <= pick ? tx_data1 : tx_data0;
            mosi     <= pick ? tx_data1[DATA_W-1] : tx_data0[DATA_W-1];
          end
        end
        S_SETUP: begin
          if (tick) begin
            state <= S_XFER;
            hp    <= '0;
          end
        end
        S_XFER: begin
          if (tick) begin
            sclk <= ~sclk;
            hp   <= hp + 1'b1;
            if (!sclk) begin
              in_bit <= rx_in;
            end else begin
              sh <= {sh[DATA_W-2:0], in_bit};
              // The last falling edge leaves mosi on the final bit.
              if (hp != XFER_LAST) mosi <= sh[DATA_W-2];
            end
            if (hp == XFER_LAST) state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (tick) begin
            cs_n    <= 2'b11;
            grant   <= 2'b00;
            done    <= owner ? 2'b10 : 2'b01;
            rx_data <= sh;
            mosi    <= 1'b0;
            hp      <= '0;
            state   <= (CS_GAP == 0) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          if (tick) begin
            hp <= hp + 1'b1;
            if (hp == GAP_LAST) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-timing reference model.
module tb_spi_txn_arbiter;

  localparam int DW = 8;
`ifdef SPI_LOOPBACK_EN
  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 0;
  localparam logic [DW-1:0] EXP_FIRST = 8'hA5;
`else
  localparam int CLK_DIV = 16;
  localparam int CS_GAP  = 2;
  localparam logic [DW-1:0] EXP_FIRST = 8'h3C;
`endif
  // Cycles with cs_n low, and cycles from grant until IDLE again.
  localparam int LX = CLK_DIV * (2 * DW + 2);
  localparam int L  = CLK_DIV * (2 * DW + 2 + CS_GAP);

  logic          clk, reset, busy, sclk, mosi, miso;
  logic [1:0]    req, grant, done, cs_n;
  logic [DW-1:0] tx_data0, tx_data1, rx_data;

  spi_txn_arbiter #(.DATA_W(DW), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .tx_data0(tx_data0), .tx_data1(tx_data1),
    .grant(grant), .done(done), .rx_data(rx_data), .busy(busy), .sclk(sclk),
    .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: one transaction record, started at grant edge t_e.
  bit            started    = 1'b0;
  bit            cur_valid  = 1'b0;
  bit            cur_who    = 1'b0;
  bit            last_srv   = 1'b1;
  int            t_e        = 0;
  int            free_at    = 0;
  logic [DW-1:0] cur_tx     = '0;
  logic [DW-1:0] cur_rx     = '0;
  logic [DW-1:0] exp_rx     = '0;
  bit            fixed_slave = 1'b0;
  logic [DW-1:0] fixed_word = '0;

  int h, f;
  bit in_cs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      started   = 1'b1;
      cur_valid = 1'b0;
      free_at   = cyc + 1;
      last_srv  = 1'b1;
      exp_rx    = '0;
    end else if (started) begin
      if (cyc >= free_at && req != 2'b00) begin
        cur_who  = (req == 2'b11) ? !last_srv : req[1];
        last_srv = cur_who;
        cur_tx   = cur_who ? tx_data1 : tx_data0;
`ifdef SPI_LOOPBACK_EN
        cur_rx   = cur_tx;
`else
        cur_rx   = fixed_slave ? fixed_word : DW'($urandom);
`endif
        t_e       = cyc;
        free_at   = cyc + L + 1;
        cur_valid = 1'b1;
      end
      if (cur_valid && cyc == t_e + LX) exp_rx = cur_rx;
    end
  end

  // Compare every output mid-cycle and drive the slave's miso.
  always @(negedge clk) begin
    if (started) begin
      in_cs = cur_valid && cyc >= t_e && cyc < t_e + LX;
      h     = in_cs ? (cyc - t_e) / CLK_DIV : 0;
      f     = (h <= 2) ? 0 : (h - 1) / 2;
      if (f > DW - 1) f = DW - 1;
      check("cs_n", 32'(cs_n), 32'(in_cs ? (cur_who ? 2'b01 : 2'b10) : 2'b11));
      check("grant", 32'(grant), 32'(in_cs ? (cur_who ? 2'b10 : 2'b01) : 2'b00));
      check("done", 32'(done),
            32'((cur_valid && cyc == t_e + LX) ? (cur_who ? 2'b10 : 2'b01) : 2'b00));
      check("busy", 32'(busy), 32'(cur_valid && cyc >= t_e && cyc < t_e + L));
      check("sclk", 32'(sclk), 32'(in_cs && h >= 2 && h <= 2 * DW && (h % 2) == 0));
      if (in_cs) check("mosi", 32'(mosi), 32'(cur_tx[DW-1-f]));
      check("rx_data", 32'(rx_data), 32'(exp_rx));
`ifdef SPI_LOOPBACK_EN
      miso = 1'($urandom_range(0, 1));
`else
      miso = in_cs ? cur_rx[DW-1-f] : 1'b0;
`endif
    end
  end

  initial begin
    reset = 1'b1; req = 2'b00; tx_data0 = '0; tx_data1 = '0; miso = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single short request from requester 0 with a fixed slave word.
    tx_data0 = 8'hA5; fixed_slave = 1'b1; fixed_word = 8'h3C;
    req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    repeat (L + 20) @(negedge clk);
    check("rx_first", 32'(rx_data), 32'(EXP_FIRST));
    check("idle_busy", 32'(busy), 32'(1'b0));
    fixed_slave = 1'b0;

    // Both requesting continuously: grants alternate.
    tx_data0 = 8'h11; tx_data1 = 8'h22; req = 2'b11;
    repeat (3 * (L + 1) + 5) @(negedge clk);
    req = 2'b00;
    repeat (L + 20) @(negedge clk);

    // Reset partway through a transfer, then a clean transfer.
    tx_data0 = DW'($urandom); req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    repeat (LX / 3 + 4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_cs_n", 32'(cs_n), 32'(2'b11));
    check("rst_sclk", 32'(sclk), 32'(1'b0));
    check("rst_grant", 32'(grant), 32'(2'b00));
    check("rst_done", 32'(done), 32'(2'b00));
    tx_data0 = DW'($urandom); req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    repeat (L + 20) @(negedge clk);

    // Requester 1 queues and its data changes while requester 0 is served.
    tx_data0 = DW'($urandom); req = 2'b01;
    @(negedge clk);
    req = 2'b10; tx_data0 = DW'($urandom);
    for (int i = 0; i < 4; i++) begin
      tx_data1 = DW'($urandom);
      repeat (LX / 4) @(negedge clk);
    end
    repeat (L + 5) @(negedge clk);
    req = 2'b00;
    repeat (L + 20) @(negedge clk);

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) req = 2'($urandom);
      tx_data0 = DW'($urandom);
      tx_data1 = DW'($urandom);
      reset    = ($urandom_range(0, 2999) == 0);
      @(negedge clk);
    end
    req = 2'b00; reset = 1'b0;
    repeat (L + 20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
